debug_ocimem_ctrl: RTL

Sysclk-domain on-chip debug memory controller for the Nios II debug core. It consumes the decoded JTAG command pulses and the `jdo` payload from the debug-slave sysclk stage. It owns a single-port debug RAM and a monitor status register, and arbitrates the RAM between JTAG accesses and the CPU's Avalon-MM debug slave. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug-slave TCK stage for shift-out.

---
 rtl/debug_ocimem_pkg.sv | 20 ++
 rtl/debug_ocimem_ram.sv | 25 ++
 rtl/debug_ocimem_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/debug_ocimem_pkg.sv
// Shared types and constants for the debug on-chip memory controller.
// Holds the FSM state enum, JDO field positions and status bit indices.
package debug_ocimem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    JRD  = 2'd1,
    CRD  = 2'd2
  } ocimem_state_e;

  localparam int JDO_ADDR_LSB = 17;
  localparam int JDO_RD_REQ   = 34;
  localparam int JDO_CLR_STAT = 35;
  localparam int JDO_DATA_MSB = 34;
  localparam int JDO_DATA_LSB = 3;

  localparam int STAT_READY = 0;
  localparam int STAT_ERROR = 1;

endpackage

// File: rtl/debug_ocimem_ram.sv
// Single-port synchronous debug RAM, 1-cycle read latency, byte-enable write.
// Ports: clk, we, be[3:0], addr[AW-1:0], wdata[31:0] -> q[31:0].
module debug_ocimem_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   q
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/debug_ocimem_ctrl.sv
// Sysclk debug memory controller: arbitrates the debug RAM between JTAG
// commands (take_* pulses + jdo) and the CPU Avalon-MM debug slave
// (avs_*), and keeps MonDReg plus the monitor_ready/monitor_error status.
module debug_ocimem_ctrl
  import debug_ocimem_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_no_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic [AW:0]   avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  input  logic [3:0]    avs_byteenable,
  output logic [31:0]   avs_readdata,
  output logic          avs_waitrequest,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error
);

  ocimem_state_e state_q, state_d;

  logic [AW-1:0] addr_q, addr_d, addr_eff;
  logic          jwr_pend, jrd_pend, jrd_inc;
  logic [31:0]   wdata_q, mon_d;

  logic [AW-1:0] jdo_addr;
  logic [31:0]   jdo_data, wr_data, ram_q;
  logic [31:0]   ram_wdata, stat_word;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_be;
  logic          ram_we;
  logic          acc_a, acc_na, acc_b;
  logic          rd_new, inc_new, clr_stat;
  logic          wr_req, rd_req, wr_done, rd_done;
  logic          set_rdy, set_err;
  logic          unused_jdo;

  assign jdo_addr = jdo[JDO_ADDR_LSB +: AW];
  assign jdo_data = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  // A pulse that would re-arm a flag already pending is dropped whole.
  assign acc_a  = take_action_ocimem_a
                & !(jdo[JDO_RD_REQ] & jrd_pend);
  assign acc_na = take_no_action_ocimem_a & !jrd_pend;
  assign acc_b  = take_action_ocimem_b & !jwr_pend;

  assign rd_new   = (acc_a & jdo[JDO_RD_REQ]) | acc_na;
  assign inc_new  = acc_na & !(acc_a & jdo[JDO_RD_REQ]);
  assign clr_stat = acc_a & jdo[JDO_CLR_STAT];

  // An accepted pulse is eligible for service in its own cycle,
  // so JTAG sees its data one cycle earlier than a registered hop.
  assign addr_eff = acc_a ? jdo_addr : addr_q;
  assign wr_req   = jwr_pend | acc_b;
  assign rd_req   = jrd_pend | rd_new;
  assign wr_data  = jwr_pend ? wdata_q : jdo_data;

  always_comb begin
    stat_word = '0;
    stat_word[STAT_READY] = monitor_ready;
    stat_word[STAT_ERROR] = monitor_error;
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_eff;
    mon_d           = acc_b ? jdo_data : MonDReg;
    ram_we          = 1'b0;
    ram_be          = 4'hF;
    ram_addr        = addr_eff;
    ram_wdata       = wr_data;
    wr_done         = 1'b0;
    rd_done         = 1'b0;
    set_rdy         = 1'b0;
    set_err         = 1'b0;
    avs_waitrequest = 1'b1;
    avs_readdata    = '0;
    unique case (state_q)
      IDLE: begin
        if (wr_req) begin
          ram_we  = 1'b1;
          addr_d  = addr_eff + AW'(1);
          wr_done = 1'b1;
        end else if (rd_req) begin
          state_d = JRD;
        end else if (avs_write) begin
          avs_waitrequest = 1'b0;
          if (avs_address[AW]) begin
            set_rdy = avs_byteenable[0]
                    & avs_writedata[STAT_READY];
            set_err = avs_writedata[STAT_ERROR];
          end else begin
            ram_we    = 1'b1;
            ram_addr  = avs_address[AW-1:0];
            ram_be    = avs_byteenable;
            ram_wdata = avs_writedata;
          end
        end else if (avs_read) begin
          ram_addr = avs_address[AW-1:0];
          state_d  = CRD;
        end
      end
      JRD: begin
        if (!acc_b) mon_d = ram_q;
        if (!acc_a) addr_d = addr_q + AW'(jrd_inc);
        rd_done = 1'b1;
        state_d = IDLE;
      end
      CRD: begin
        avs_waitrequest = 1'b0;
        avs_readdata    = avs_address[AW] ? stat_word : ram_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      jwr_pend      <= 1'b0;
      jrd_pend      <= 1'b0;
      jrd_inc       <= 1'b0;
      wdata_q       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      jwr_pend <= (jwr_pend | acc_b) & !wr_done;
      jrd_pend <= (jrd_pend | rd_new) & !rd_done;
      if (rd_new) jrd_inc <= inc_new;
      if (acc_b) wdata_q <= jdo_data;
      MonDReg  <= mon_d;
      // Set beats clear when both land in one cycle.
      monitor_ready <= (monitor_ready & !clr_stat) | set_rdy;
      monitor_error <= (monitor_error & !clr_stat) | set_err;
    end
  end

  // Reset gates the write so an abort edge never corrupts RAM.
  debug_ocimem_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we & !reset),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

endmodule
